// File: rtl/counter_slot_arbiter_if.sv
// Bus between the slot arbiter, its requesters and the shared up-counter.
// The arbiter side uses the slave modport. Requesters and the counter use the master modport.
interface counter_slot_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 10
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] i_req;
  logic [WIDTH-1:0]   i_slot_len;
  logic [WIDTH-1:0]   i_count;
  logic               o_cnt_en;
  logic               o_cnt_clear;
  logic [NUM_REQ-1:0] o_gnt;
  logic [IDXW-1:0]    o_gnt_idx;
  logic               o_busy;
  logic               o_slot_expired;

  modport slave (
    input  i_req, i_slot_len, i_count,
    output o_cnt_en, o_cnt_clear, o_gnt, o_gnt_idx, o_busy, o_slot_expired
  );

  modport master (
    output i_req, i_slot_len, i_count,
    input  o_cnt_en, o_cnt_clear, o_gnt, o_gnt_idx, o_busy, o_slot_expired
  );
endinterface

// File: rtl/counter_slot_arbiter.sv
// Round-robin time-slot arbiter that shares one external up-counter between NUM_REQ requesters.
// Optional expiry statistics are enabled by defining COUNTER_SLOT_ARB_STATS_EN.
module counter_slot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  counter_slot_arbiter_if.slave  bus
`ifdef COUNTER_SLOT_ARB_STATS_EN
  ,
  input  logic                   i_stats_clear,
  output logic [7:0]             o_expired_total
`endif
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   len_q, len_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               exp_q, exp_d;

  logic               found;
  logic [IDXW-1:0]    win_idx;
  logic [IDXW-1:0]    cand;

  // First requester strictly after the last grantee, wrapping around
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.i_req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gnt_d   = gnt_q;
    exp_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = GRANT;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          ptr_d          = win_idx;
          len_d          = (bus.i_slot_len == '0) ? WIDTH'(1) : bus.i_slot_len;
        end
      end
      GRANT: begin
        // Reaching the length wins over a release in the same cycle
        if (bus.i_count == len_q - WIDTH'(1)) begin
          state_d = GAP;
          gnt_d   = '0;
          exp_d   = 1'b1;
        end else if (!bus.i_req[idx_q]) begin
          state_d = GAP;
          gnt_d   = '0;
        end
      end
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= IDXW'(NUM_REQ - 1);
      idx_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      exp_q   <= exp_d;
    end
  end

  // The counter is held clear outside GRANT, so it reads 0 on the first granted cycle
  assign bus.o_cnt_en       = (state_q == GRANT);
  assign bus.o_cnt_clear    = (state_q != GRANT);
  assign bus.o_busy         = (state_q == GRANT);
  assign bus.o_gnt          = gnt_q;
  assign bus.o_gnt_idx      = idx_q;
  assign bus.o_slot_expired = exp_q;

`ifdef COUNTER_SLOT_ARB_STATS_EN
  logic [7:0] tot_q, tot_d;

  always_comb begin
    tot_d = tot_q;
    if (i_stats_clear)
      tot_d = '0;
    else if (exp_q && tot_q != 8'hFF)
      tot_d = tot_q + 8'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tot_q <= '0;
    else       tot_q <= tot_d;
  end

  assign o_expired_total = tot_q;
`endif

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed bench for counter_slot_arbiter with a behavioural model of the shared counter.
module tb_counter_slot_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       stats_clear = 1'b0;
  logic [7:0] exp_total;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_slot_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  counter_slot_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
`ifdef COUNTER_SLOT_ARB_STATS_EN
    ,
    .i_stats_clear(stats_clear),
    .o_expired_total(exp_total)
`endif
  );

`ifndef COUNTER_SLOT_ARB_STATS_EN
  assign exp_total = 8'h00;
`endif

  // Shared up-counter with synchronous clear
  always @(posedge clk) begin
    if (bus.o_cnt_clear)   bus.i_count <= '0;
    else if (bus.o_cnt_en) bus.i_count <= bus.i_count + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for a grant, checks it, measures its width and checks the GAP cycle
  task automatic run_slot(input string tag, input int idx, input int len, input bit expx,
                          input int new_len);
    int t;
    int w;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.o_gnt == '0 && t < 100);
    chk({tag, ":gnt"},    32'(bus.o_gnt), 32'(1 << idx));
    chk({tag, ":idx"},    32'(bus.o_gnt_idx), 32'(idx));
    chk({tag, ":cnt_en"}, 32'(bus.o_cnt_en), 32'd1);
    chk({tag, ":busy"},   32'(bus.o_busy), 32'd1);
    if (new_len >= 0) bus.i_slot_len = WIDTH'(new_len);
    w = 0;
    while (bus.o_gnt != '0 && w < 2000) begin w++; @(negedge clk); end
    chk({tag, ":width"},   32'(w), 32'(len));
    chk({tag, ":expired"}, 32'(bus.o_slot_expired), 32'(expx));
    chk({tag, ":gap_clr"}, 32'(bus.o_cnt_clear), 32'd1);
    chk({tag, ":gap_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req      = '0;
    bus.i_slot_len = '0;
    bus.i_count    = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst:gnt",     32'(bus.o_gnt), 32'd0);
    chk("rst:idx",     32'(bus.o_gnt_idx), 32'd0);
    chk("rst:busy",    32'(bus.o_busy), 32'd0);
    chk("rst:expired", 32'(bus.o_slot_expired), 32'd0);
    chk("rst:clr",     32'(bus.o_cnt_clear), 32'd1);
    chk("rst:en",      32'(bus.o_cnt_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle:no_req", 32'(bus.o_gnt), 32'd0);

    // Single requester, L=5, then regrant after two idle cycles and early release
    bus.i_slot_len = 10'd5;
    bus.i_req      = 4'b0001;
    run_slot("single", 0, 5, 1'b1, -1);
    @(negedge clk);
    chk("single:pulse_once", 32'(bus.o_slot_expired), 32'd0);
    chk("single:idle_gnt",   32'(bus.o_gnt), 32'd0);
    chk("single:idle_clr",   32'(bus.o_cnt_clear), 32'd1);
    @(negedge clk);
    chk("single:regrant",    32'(bus.o_gnt), 32'd1);
    bus.i_req = '0;
    @(negedge clk);
    chk("single:rel_gnt",    32'(bus.o_gnt), 32'd0);
    chk("single:rel_noexp",  32'(bus.o_slot_expired), 32'd0);
    @(negedge clk);

    // Requester 2 alone, L=10, releases after 4 granted cycles
    bus.i_slot_len = 10'd10;
    bus.i_req      = 4'b0100;
    @(negedge clk);
    chk("rel:gnt", 32'(bus.o_gnt), 32'b0100);
    chk("rel:idx", 32'(bus.o_gnt_idx), 32'd2);
    repeat (3) @(negedge clk);
    chk("rel:held", 32'(bus.o_gnt), 32'b0100);
    bus.i_req = '0;
    @(negedge clk);
    chk("rel:drop",    32'(bus.o_gnt), 32'd0);
    chk("rel:noexp",   32'(bus.o_slot_expired), 32'd0);
    chk("rel:gap",     32'(bus.o_busy), 32'd0);
    @(negedge clk);
    chk("rel:idle",    32'(bus.o_gnt), 32'd0);
    chk("rel:idx_hold", 32'(bus.o_gnt_idx), 32'd2);

    // Slot length corner cases
    bus.i_slot_len = 10'd0;
    bus.i_req      = 4'b0001;
    run_slot("len0", 0, 1, 1'b1, -1);
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    bus.i_slot_len = 10'd1023;
    bus.i_req      = 4'b0001;
    run_slot("len1023", 0, 1023, 1'b1, 2);
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    bus.i_slot_len = 10'd4;
    bus.i_req      = 4'b0001;
    run_slot("midchg", 0, 4, 1'b1, 9);
    bus.i_req = '0;
    repeat (2) @(negedge clk);

    // Reset mid-grant: pointer returns so requester 0 wins next
    bus.i_slot_len = 10'd8;
    bus.i_req      = 4'b0111;
    @(negedge clk);
    chk("rstmid:gnt", 32'(bus.o_gnt), 32'b0010);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid:gnt_drop", 32'(bus.o_gnt), 32'd0);
    chk("rstmid:clr",      32'(bus.o_cnt_clear), 32'd1);
    chk("rstmid:busy",     32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_slot("rstmid_next", 0, 8, 1'b1, -1);
    bus.i_req = '0;
    repeat (2) @(negedge clk);

    // Round robin with all four requesting, L=3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_slot_len = 10'd3;
    bus.i_req      = 4'b1111;
    run_slot("rr0", 0, 3, 1'b1, -1);
    run_slot("rr1", 1, 3, 1'b1, -1);
    run_slot("rr2", 2, 3, 1'b1, -1);
    run_slot("rr3", 3, 3, 1'b1, -1);
    run_slot("rr0b", 0, 3, 1'b1, -1);
    bus.i_req = '0;
    repeat (2) @(negedge clk);

`ifdef COUNTER_SLOT_ARB_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stats:rst", 32'(exp_total), 32'd0);
    bus.i_slot_len = 10'd0;
    bus.i_req      = 4'b0001;
    for (int i = 0; i < 300; i++) run_slot("stats", 0, 1, 1'b1, -1);
    @(negedge clk);
    chk("stats:sat", 32'(exp_total), 32'd255);
    run_slot("stats_clr", 0, 1, 1'b1, -1);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    chk("stats:clr_prio", 32'(exp_total), 32'd0);
    run_slot("stats_inc", 0, 1, 1'b1, -1);
    @(negedge clk);
    chk("stats:inc", 32'(exp_total), 32'd1);
    bus.i_req = '0;
    repeat (2) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_slot_arbiter.md
Name: counter_slot_arbiter

Overview:
Time-slot arbiter that shares one external up-counter between NUM_REQ requesters. It grants one requester at a time, round-robin, for a programmable number of cycles. It drives the counter's enable/clear and watches the returned count to end each slot. It sits between requester logic and a single shared counter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 10, counter / slot-length width in bits

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
i_req  input  NUM_REQ  per-requester request level; held high while the slot is wanted
i_slot_len  input  WIDTH  slot length in cycles; sampled on the grant-start edge
i_count  input  WIDTH  current value from the shared counter
o_cnt_en  output  1  counter enable
o_cnt_clear  output  1  counter synchronous clear
o_gnt  output  NUM_REQ  one-hot grant, registered
o_gnt_idx  output  $clog2(NUM_REQ)  index of the current or last grantee
o_busy  output  1  high while in GRANT
o_slot_expired  output  1  one-cycle pulse when a slot ends by reaching its length

Behaviour:
- Reset (async): state IDLE; o_gnt=0; o_gnt_idx=0; o_slot_expired=0; latched length=0; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, GRANT, GAP.
- Counter control is combinational from state:
  - GRANT: o_cnt_en=1, o_cnt_clear=0.
  - IDLE/GAP: o_cnt_en=0, o_cnt_clear=1.
  - The counter is therefore 0 on the first GRANT cycle. During reset, clear=1 and en=0.
- IDLE: if any i_req is high, choose the first set bit searching from pointer+1 with wrap.
  - Next edge: state GRANT, o_gnt one-hot, o_gnt_idx=winner, pointer=winner, latch L=i_slot_len.
  - L=0 is treated as 1.
  - No request: stay in IDLE.
- GRANT, expiry: slot ends when i_count==L-1 with the grantee's i_req still high.
  - Next edge: GAP, o_gnt=0, o_slot_expired=1 for that one cycle.
  - o_gnt is high for exactly L cycles.
- GRANT, early release: grantee's i_req low and not the expiry cycle.
  - Next edge: GAP, o_gnt=0, no expired pulse.
- Simultaneous release and expiry on the same cycle: counts as expiry (pulse asserted).
- GAP: one turnaround cycle, then IDLE unconditionally.
  - Back-to-back grants are separated by at least 2 cycles with o_gnt=0 (GAP + IDLE).
- Requests from non-granted requesters during GRANT are ignored. They are arbitrated in the next IDLE.
- i_slot_len changes mid-grant have no effect.
- o_busy=1 exactly in GRANT. o_gnt is all-zero outside GRANT.
- Reset asserted mid-grant: o_gnt drops immediately (async), o_cnt_clear=1, pointer returns to NUM_REQ-1.
- i_count is compared only in GRANT. A counter stuck below L-1 holds the grant until release. No timeout in the base block.
- Width rules: the comparison is WIDTH bits, unsigned. L=2^WIDTH-1 is the maximum slot.

Optional Feature:
- Macro COUNTER_SLOT_ARB_STATS_EN.
- Defined:
  - Adds input i_stats_clear (1 bit) and output o_expired_total (8 bits).
  - o_expired_total counts o_slot_expired pulses, saturates at 255, resets to 0.
  - i_stats_clear zeroes it synchronously and has priority over a coincident increment.
- Undefined: neither port exists and no counter logic is generated.
- Arbitration behaviour is identical either way.

Test Plan:
- Single requester, i_req[0]=1, i_slot_len=5, counter model attached -> o_gnt=0001 for exactly 5 cycles; o_slot_expired pulses once; o_cnt_clear=1 in GAP/IDLE; regrant after 2 idle cycles.
- All four requesting continuously, L=3 -> grant order 0,1,2,3,0,...; each o_gnt pulse 3 cycles wide; o_gnt_idx tracks the grantee.
- Requester 2 alone, L=10, drops i_req after 4 granted cycles -> o_gnt falls the next edge; no o_slot_expired pulse; state passes GAP then IDLE.
- i_slot_len=0 -> 1-cycle grant with expiry pulse. i_slot_len=1023 -> 1023-cycle grant. Changing i_slot_len mid-grant does not alter length.
- Assert i_rst for 1 cycle mid-grant (L=8, cycle 3) -> o_gnt=0 immediately; next grant goes to requester 0 if it is requesting.
- With COUNTER_SLOT_ARB_STATS_EN: 300 expiries -> o_expired_total=255; i_stats_clear coincident with an expiry -> 0.
